// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register
// offsets, STATUS bit layout and the transmit FSM state encoding.
package uart_pkg;

    localparam logic [31:0] REG_TXDATA = 32'd0;
    localparam logic [31:0] REG_STATUS = 32'd4;

    localparam int STAT_SHIFTING_BIT = 0;
    localparam int STAT_EMPTY_BIT    = 1;
    localparam int STAT_FULL_BIT     = 2;
    localparam int STAT_OVF_BIT      = 3;
    localparam int STAT_COUNT_LSB    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count. Pushes into a full FIFO and
// pops from an empty FIFO are ignored; the head entry is always visible.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage array: write the pushed entry at the write pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            wr_ptr_r <= do_push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
            rd_ptr_r <= do_pop_s  ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        end
    end

    // Occupancy: simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter. CPU byte writes to TXDATA are queued
// in a small FIFO and shifted out LSB first; STATUS reports queue state and
// a sticky overflow flag. Read data is zero outside STATUS reads so it can
// be OR-merged with RAM read data.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        w_r,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        busy
);

    localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
    localparam int                CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0]       TXDATA_ADDR = BASE_ADDR + REG_TXDATA;
    localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + REG_STATUS;

    tx_state_e         state_r, state_next_s;
    logic [BAUD_W-1:0] baud_r, baud_next_s;
    logic [2:0]        idx_r, idx_next_s;
    logic [7:0]        shreg_r, shreg_next_s;
    logic              tx_r, tx_next_s;
    logic              ovf_r;

    logic              wr_txdata_s, wr_status_s, rd_status_s;
    logic              push_s, pop_s;
    logic [7:0]        head_s;
    logic              full_s, empty_s, shifting_s;
    logic [CNT_W-1:0]  count_s;
    logic [3:0]        count_ext_s;
    logic              unused_s;

    assign wr_txdata_s = w_r  & (addr == TXDATA_ADDR);
    assign wr_status_s = w_r  & (addr == STATUS_ADDR);
    assign rd_status_s = ~w_r & (addr == STATUS_ADDR);
    assign push_s      = wr_txdata_s & ~full_s;
    assign shifting_s  = (state_r != ST_IDLE);
    assign busy        = shifting_s | ~empty_s;
    assign tx          = tx_r;
    assign count_ext_s = 4'(count_s);
    assign unused_s    = ^{wr_data[31:8], count_ext_s[3]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (wr_data[7:0]),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    // Frame sequencer: next state, baud countdown, bit index and FIFO pop.
    always_comb begin
        state_next_s = state_r;
        baud_next_s  = baud_r;
        idx_next_s   = idx_r;
        shreg_next_s = shreg_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    shreg_next_s = head_s;
                    baud_next_s  = BAUD_RELOAD;
                    state_next_s = ST_START;
                end else begin
                    baud_next_s  = '0;
                end
            end
            ST_START: begin
                if (baud_r == '0) begin
                    baud_next_s  = BAUD_RELOAD;
                    idx_next_s   = 3'd0;
                    state_next_s = ST_DATA;
                end else begin
                    baud_next_s  = baud_r - BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_r == '0) begin
                    baud_next_s = BAUD_RELOAD;
                    if (idx_r == 3'd7) begin
                        state_next_s = ST_STOP;
                    end else begin
                        idx_next_s   = idx_r + 3'd1;
                    end
                end else begin
                    baud_next_s = baud_r - BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_r == '0) begin
                    if (!empty_s) begin
                        // Next frame starts with no idle gap.
                        pop_s        = 1'b1;
                        shreg_next_s = head_s;
                        baud_next_s  = BAUD_RELOAD;
                        state_next_s = ST_START;
                    end else begin
                        baud_next_s  = '0;
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    baud_next_s = baud_r - BAUD_W'(1);
                end
            end
            default: begin
                baud_next_s  = '0;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Line level is derived from the upcoming state so tx lines up with it.
    always_comb begin
        tx_next_s = 1'b1;
        case (state_next_s)
            ST_IDLE:  tx_next_s = 1'b1;
            ST_START: tx_next_s = 1'b0;
            ST_DATA:  tx_next_s = shreg_next_s[idx_next_s];
            ST_STOP:  tx_next_s = 1'b1;
            default:  tx_next_s = 1'b1;
        endcase
    end

    // Transmit datapath registers; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            baud_r  <= '0;
            idx_r   <= 3'd0;
            shreg_r <= 8'd0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_next_s;
            baud_r  <= baud_next_s;
            idx_r   <= idx_next_s;
            shreg_r <= shreg_next_s;
            tx_r    <= tx_next_s;
        end
    end

    // Sticky overflow: set by a TXDATA write into a full FIFO, cleared via STATUS bit 3.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_r <= 1'b0;
        end else if (wr_txdata_s && full_s) begin
            ovf_r <= 1'b1;
        end else if (wr_status_s && wr_data[STAT_OVF_BIT]) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Read mux: only a STATUS read drives non-zero data.
    always_comb begin
        rd_data = 32'd0;
        if (rd_status_s) begin
            rd_data[STAT_SHIFTING_BIT]       = shifting_s;
            rd_data[STAT_EMPTY_BIT]          = empty_s;
            rd_data[STAT_FULL_BIT]           = full_s;
            rd_data[STAT_OVF_BIT]            = ovf_r;
            rd_data[STAT_COUNT_LSB +: 3]     = count_ext_s[2:0];
        end else begin
            rd_data = 32'd0;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Expected line waveforms are built from the 8N1 frame definition and a
// queue model of the FIFO; STATUS expectations come from that same model.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] STATUS = BASE + 32'd4;
    localparam int          CPB    = 4;
    localparam int          DEPTH  = 4;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        w_r;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        tx;
    logic        busy;

    int   vectors;
    int   miscompares;
    bit   model_ovf;
    logic [7:0] burst_bytes [8];

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .w_r     (w_r),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .tx      (tx),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] idle_status();
        return model_ovf ? 32'h0000_000A : 32'h0000_0002;
    endfunction

    task automatic test_reset();
        rst = 1'b0; w_r = 1'b0; addr = 32'd0; wr_data = 32'd0;
        model_ovf = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b expected 1", tx); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b1; addr = STATUS;
        #1;
        vectors++;
        if (rd_data !== 32'h0000_0002) begin
            miscompares++; $display("FAIL reset_status: got %h expected 00000002", rd_data);
        end
    endtask

    // Writes burst_bytes[0..n-1] on n consecutive edges from an idle line and
    // checks tx/busy every cycle plus STATUS after the last write and at the end.
    task automatic run_burst(input int n, input string tag);
        logic [7:0]  q[$];
        logic [7:0]  sent[$];
        bit          exp_bits[$];
        bit          started;
        bit          nonempty_idle;
        bit          exp_tx;
        bit          exp_busy;
        int          frames;
        int          sz;
        logic [31:0] st_exp;
        logic [31:0] rnd;
        logic [7:0]  b;

        started = 1'b0;
        for (int i = 0; i < n; i++) begin
            nonempty_idle = !started && (q.size() > 0);
            if (q.size() < DEPTH) q.push_back(burst_bytes[i]);
            else model_ovf = 1'b1;
            if (nonempty_idle) begin
                sent.push_back(q.pop_front());
                started = 1'b1;
            end
        end
        sz = q.size();
        st_exp = {25'd0, 3'(sz), model_ovf, (sz == DEPTH), (sz == 0), started};
        for (int i = 0; i < sz; i++) sent.push_back(q[i]);
        frames = sent.size();
        for (int f = 0; f < frames; f++) begin
            b = sent[f];
            exp_bits.push_back(1'b0);
            for (int k = 0; k < 8; k++) exp_bits.push_back(b[k]);
            exp_bits.push_back(1'b1);
        end

        @(negedge clk);
        rnd = $urandom; addr = BASE; w_r = 1'b1; wr_data = {rnd[31:8], burst_bytes[0]};
        for (int c = 0; c <= 40 * frames + 1; c++) begin
            @(negedge clk);
            if (c == 0) exp_tx = 1'b1;
            else if ((c - 1) / CPB < 10 * frames) exp_tx = exp_bits[(c - 1) / CPB];
            else exp_tx = 1'b1;
            exp_busy = (c <= 40 * frames);
            vectors++;
            if (tx !== exp_tx) begin
                miscompares++; $display("FAIL %s tx c=%0d: got %b expected %b", tag, c, tx, exp_tx);
            end
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++; $display("FAIL %s busy c=%0d: got %b expected %b", tag, c, busy, exp_busy);
            end
            rnd = $urandom;
            if (c < n - 1) begin
                wr_data = {rnd[31:8], burst_bytes[c + 1]};
            end else begin
                addr = STATUS; w_r = 1'b0; wr_data = rnd;
            end
            if (c == n - 1) begin
                #1;
                vectors++;
                if (rd_data !== st_exp) begin
                    miscompares++; $display("FAIL %s status_after_writes: got %h expected %h", tag, rd_data, st_exp);
                end
            end
            if (c == 40 * frames + 1) begin
                #1;
                vectors++;
                if (rd_data !== idle_status()) begin
                    miscompares++; $display("FAIL %s status_end: got %h expected %h", tag, rd_data, idle_status());
                end
            end
        end
    endtask

    task automatic test_single_byte();
        burst_bytes[0] = 8'h55;
        run_burst(1, "single_55");
        burst_bytes[0] = 8'($urandom);
        run_burst(1, "single_rand");
    endtask

    task automatic test_burst_overflow();
        for (int i = 0; i < 6; i++) burst_bytes[i] = 8'(i + 1);
        run_burst(6, "burst_ovf");
    endtask

    task automatic test_clear_ovf();
        logic [31:0] rnd;
        rnd = $urandom;
        @(negedge clk);
        addr = STATUS; w_r = 1'b1; wr_data = rnd & ~32'h8;
        @(negedge clk);
        w_r = 1'b0;
        #1;
        vectors++;
        if (rd_data !== idle_status()) begin
            miscompares++; $display("FAIL ovf_keep: got %h expected %h", rd_data, idle_status());
        end
        @(negedge clk);
        w_r = 1'b1; wr_data = 32'h0000_0008;
        @(negedge clk);
        w_r = 1'b0;
        model_ovf = 1'b0;
        #1;
        vectors++;
        if (rd_data !== 32'h0000_0002) begin
            miscompares++; $display("FAIL ovf_clear: got %h expected 00000002", rd_data);
        end
    endtask

    task automatic test_random_bursts();
        int n;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(7, 1);
            for (int i = 0; i < 8; i++) burst_bytes[i] = 8'($urandom);
            run_burst(n, "rand_burst");
        end
    endtask

    task automatic test_decode();
        logic [31:0] a;
        @(negedge clk);
        addr = BASE + 32'd8; w_r = 1'b1; wr_data = $urandom;
        @(negedge clk);
        w_r = 1'b0;
        #1;
        vectors++;
        if (rd_data !== 32'd0) begin miscompares++; $display("FAIL dec_rd_base8: got %h expected 0", rd_data); end
        addr = BASE;
        #1;
        vectors++;
        if (rd_data !== 32'd0) begin miscompares++; $display("FAIL dec_rd_base: got %h expected 0", rd_data); end
        a = BASE + 32'd4 * 32'($urandom_range(100, 2));
        addr = a;
        #1;
        vectors++;
        if (rd_data !== 32'd0) begin miscompares++; $display("FAIL dec_rd_other: got %h expected 0", rd_data); end
        addr = STATUS; w_r = 1'b1; wr_data = 32'd0;
        #1;
        vectors++;
        if (rd_data !== 32'd0) begin miscompares++; $display("FAIL dec_wr_status_rd: got %h expected 0", rd_data); end
        @(negedge clk);
        addr = BASE; w_r = 1'b0; wr_data = $urandom;
        repeat (3) @(negedge clk);
        addr = STATUS;
        for (int c = 0; c < 8; c++) begin
            #1;
            vectors++;
            if (tx !== 1'b1 || rd_data !== idle_status()) begin
                miscompares++;
                $display("FAIL dec_no_push c=%0d: got tx=%b status=%h expected tx=1 status=%h", c, tx, rd_data, idle_status());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        @(negedge clk);
        addr = BASE; w_r = 1'b1; wr_data = 32'h0000_00A5;
        @(negedge clk);
        b = 8'($urandom); wr_data = {24'd0, b};
        @(negedge clk);
        w_r = 1'b0; addr = STATUS;
        repeat (9) @(negedge clk);
        #1;
        vectors++;
        if (tx !== 1'b0) begin miscompares++; $display("FAIL mid_tx_before: got %b expected 0", tx); end
        vectors++;
        if (rd_data !== 32'h0000_0011) begin
            miscompares++; $display("FAIL mid_status_before: got %h expected 00000011", rd_data);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL mid_tx_async: got %b expected 1", tx); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy_async: got %b expected 0", busy); end
        model_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (tx !== 1'b1 || rd_data !== 32'h0000_0002) begin
                miscompares++;
                $display("FAIL mid_after c=%0d: got tx=%b status=%h expected tx=1 status=00000002", c, tx, rd_data);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single_byte();
        test_burst_overflow();
        test_clear_ovf();
        test_random_bursts();
        test_decode();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter that responds to the CPU data-memory port (`addr_out` / `we_out` / `store_data_out` / `load_data_in`) alongside `RAM`. It accepts byte writes from the CPU into a small TX FIFO and serializes them 8N1, LSB first, on `tx`. Reads return a status word, and its `rd_data` is zero outside its own window so it can be OR-merged with `RAM` read data.

## Interface
- `BASE_ADDR`, 32'h0000_1000: byte address of TXDATA; STATUS is at `BASE_ADDR+4`.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 4: TX FIFO entries; must be a power of 2, ≤ 8.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `addr`  in  32  CPU data address.
- `w_r`  in  1  1 = write this cycle, 0 = read.
- `wr_data`  in  32  CPU store data.
- `rd_data`  out  32  combinational read data.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  1 while a frame is on the line or the FIFO is non-empty.

## Operation
- **TXDATA write** (`w_r`=1, `addr`==BASE): at the clock edge, push `wr_data[7:0]` if the FIFO is not full before that edge. Otherwise drop the byte and set sticky `ovf`. A pop in the same cycle does not make room.
- **STATUS write** (`w_r`=1, `addr`==BASE+4): `wr_data[3]`=1 clears `ovf`. All other bits are ignored.
- **STATUS read** (`w_r`=0, `addr`==BASE+4): `rd_data` = {25'b0, count[2:0], ovf, full, empty, shifting}.
  - Bits [6:4] are `count`.
  - Bit 0 `shifting` = FSM not in IDLE.
- All other address or direction combinations: `rd_data`=0 and no state change. Reads have no side effects.
- `busy` = `shifting` | ~`empty`.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, load the baud counter with CLKS_PER_BIT-1, and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: `tx`=shreg[idx] for CLKS_PER_BIT cycles each, idx 0..7. After idx 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- **Baud counter:** counts down and reloads CLKS_PER_BIT-1 at every bit boundary. Width is $clog2(CLKS_PER_BIT).
- **FIFO counters:** pointers wrap modulo FIFO_DEPTH. `count` width is $clog2(FIFO_DEPTH)+1. Simultaneous push and pop leaves `count` unchanged.

## Timing
- **Reset values:** `tx`=1, `busy`=0, FSM=IDLE, FIFO empty, `count`=0, `ovf`=0, baud counter=0, shreg=0. STATUS reads 32'h0000_0002.
- **Reset mid-frame:** `tx` returns to 1 asynchronously, the frame is aborted, and the FIFO is flushed.
- **Write latency:**
  - A write at edge N makes `count`=1 after edge N.
  - If the FSM is idle, the pop happens at edge N+1 and `tx` falls after edge N+1.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- **No handshake:** CPU writes are single-cycle with no stall. The CPU must poll `full` to avoid drops.

## Structure
- Shared package `uart_pkg`:
  - Register offsets: TXDATA=0, STATUS=4.
  - STATUS bit positions.
  - FSM state encoding: 2-bit, IDLE=0, START=1, DATA=2, STOP=3.
- Sub-module `sync_fifo`:
  - Parameters: WIDTH=8, DEPTH.
  - Ports: push/pop, full/empty/count.
  - Same clk/rst, asynchronous active-low reset.
- Top contains the address decode, `ovf`, the FSM, baud counter and shift register.

## Test plan
All scenarios use CLKS_PER_BIT=4, FIFO_DEPTH=4.
1. **Reset:** hold `rst`=0 → `tx`=1, `busy`=0. After release, read BASE+4 → 32'h0000_0002.
2. **Single byte:** write 32'h55 to BASE at edge N.
   - `tx`=0 from edge N+1 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then stop=1.
   - `busy` deasserts 40 cycles after N+1.
3. **Burst and overflow:** write 0x01..0x06 to BASE on six consecutive cycles from idle.
   - 0x01 is popped immediately and 0x02..0x05 fill the FIFO; 0x06 is dropped.
   - STATUS = 32'h0000_004D.
   - `tx` carries five contiguous frames (200 cycles, no gap) with data 01..05.
4. **Clear overflow:** after scenario 3, write 32'h8 to BASE+4 → STATUS bit3=0. Other bits are unchanged.
5. **Decode isolation:**
   - Write to BASE+8 → no FIFO change, `tx` stays 1.
   - Read BASE or BASE+8 → `rd_data`=0.
   - `w_r`=0 with `addr`=BASE → no push.
6. **Reset mid-frame:** start 0xA5 plus one queued byte; assert `rst` during DATA.
   - `tx`=1 immediately.
   - After release, STATUS=32'h0000_0002 and no further frames appear.
